// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined IEEE-754 multiplier (RNE, DAZ/FTZ) with valid/ready and global stall.
// Define FP_MUL_FLAGS_EN to build the {invalid, overflow, underflow, inexact} flag logic.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] input_a,
    input  logic [W-1:0] input_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int XW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam int FW = MAN_W + 1;
    typedef logic signed [XW-1:0] exp_t;
    localparam exp_t BIAS = exp_t'((1 << (EXP_W - 1)) - 1);
    localparam exp_t EMAX = exp_t'((1 << EXP_W) - 1);
    localparam logic [1:0] C_NUM = 2'd0, C_NAN = 2'd1, C_INF = 2'd2, C_ZERO = 2'd3;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
    localparam logic [3:0] FLAG_MASK = 4'hf;
`else
    localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

    logic stall;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic za, zb, ia, ib, na, nb, inf_zero, snan;
    logic [1:0] cls_n;
    exp_t exp_n;
    logic v1, v2, v3;
    logic s1_sign, s2_sign, s3_sign;
    exp_t s1_exp, s2_exp, s3_exp;
    logic [1:0] s1_cls, s2_cls, s3_cls;
    logic s1_inv, s2_inv, s3_inv;
    logic [MAN_W:0] s1_ma, s1_mb;
    logic [PW-1:0] s2_prod;
    logic msb;
    logic [MAN_W-1:0] s3_frac, frac_r;
    logic s3_g, s3_st, rup, carry, ovf, unf;
    exp_t exp_f;
    logic [W-1:0] res_n;
    logic [3:0] flg_n;

    assign stall = out_valid && !out_ready;
    assign in_ready = !stall;

    // Subnormals (exponent field zero) classify as zero.
    assign ea = input_a[W-2 -: EXP_W];
    assign eb = input_b[W-2 -: EXP_W];
    assign fa = input_a[MAN_W-1:0];
    assign fb = input_b[MAN_W-1:0];
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = &ea && fa == '0;
    assign ib = &eb && fb == '0;
    assign na = &ea && fa != '0;
    assign nb = &eb && fb != '0;
    assign inf_zero = (ia && zb) || (ib && za);
    assign snan = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]);
    assign cls_n = (na || nb || inf_zero) ? C_NAN : (ia || ib) ? C_INF : (za || zb) ? C_ZERO : C_NUM;
    assign exp_n = exp_t'({2'b00, ea}) + exp_t'({2'b00, eb}) - BIAS;

    assign msb = s2_prod[PW-1];

    assign rup = s3_g && (s3_st || s3_frac[0]);
    assign {carry, frac_r} = {1'b0, s3_frac} + FW'(rup);
    assign exp_f = carry ? s3_exp + exp_t'(1) : s3_exp;
    assign ovf = exp_f >= EMAX;
    assign unf = exp_f <= exp_t'(0);
    assign res_n = s3_cls == C_NAN ? QNAN
                 : (s3_cls == C_INF || (s3_cls == C_NUM && ovf)) ? {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                 : (s3_cls == C_ZERO || unf) ? {s3_sign, {(W-1){1'b0}}}
                 : {s3_sign, exp_f[EXP_W-1:0], frac_r};
    assign flg_n = s3_cls == C_NAN ? {s3_inv, 3'b000}
                 : s3_cls != C_NUM ? 4'b0000
                 : ovf ? 4'b0101
                 : unf ? 4'b0011
                 : {3'b000, s3_g || s3_st};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, v3, out_valid} <= '0;
            {s1_sign, s2_sign, s3_sign} <= '0;
            {s1_exp, s2_exp, s3_exp} <= '0;
            {s1_cls, s2_cls, s3_cls} <= '0;
            {s1_inv, s2_inv, s3_inv} <= '0;
            {s1_ma, s1_mb, s2_prod} <= '0;
            {s3_frac, s3_g, s3_st} <= '0;
            result <= '0;
            flags <= '0;
        end else if (!stall) begin
            v1 <= in_valid;
            s1_sign <= input_a[W-1] ^ input_b[W-1];
            s1_exp <= exp_n;
            s1_cls <= cls_n;
            s1_inv <= inf_zero || snan;
            s1_ma <= {1'b1, fa};
            s1_mb <= {1'b1, fb};
            v2 <= v1;
            s2_sign <= s1_sign;
            s2_exp <= s1_exp;
            s2_cls <= s1_cls;
            s2_inv <= s1_inv;
            s2_prod <= PW'(s1_ma) * PW'(s1_mb);
            v3 <= v2;
            s3_sign <= s2_sign;
            s3_cls <= s2_cls;
            s3_inv <= s2_inv;
            s3_exp <= msb ? s2_exp + exp_t'(1) : s2_exp;
            s3_frac <= msb ? s2_prod[PW-2 -: MAN_W] : s2_prod[PW-3 -: MAN_W];
            s3_g <= msb ? s2_prod[MAN_W] : s2_prod[MAN_W-1];
            s3_st <= msb ? |s2_prod[MAN_W-1:0] : |s2_prod[MAN_W-2:0];
            out_valid <= v3;
            if (v3) begin
                result <= res_n;
                flags <= flg_n & FLAG_MASK;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed checks of fp_mul_pipe (binary32 and binary16 instances).
module tb_fp_mul_pipe;
`ifdef FP_MUL_FLAGS_EN
    localparam logic [3:0] FMASK = 4'hf;
`else
    localparam logic [3:0] FMASK = 4'h0;
`endif
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    logic clk = 0;
    logic rst_n = 1;
    logic in_valid = 0;
    logic out_ready = 1;
    logic in_ready, out_valid;
    logic [31:0] a = 0, b = 0, result;
    logic [3:0] flags;
    logic h_valid = 0;
    logic h_in_ready, h_out_valid;
    logic [15:0] ha = 0, hb = 0, h_result;
    logic [3:0] h_flags;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .input_a(a), .input_b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_valid), .in_ready(h_in_ready),
        .input_a(ha), .input_b(hb), .out_valid(h_out_valid), .out_ready(1'b1),
        .result(h_result), .flags(h_flags)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        vectors++; if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 00000000", result); end
        vectors++; if (flags !== 4'h0) begin errors++; $display("FAIL reset flags: got %b want 0000", flags); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        rst_n = 1;
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL post-reset idle: got valid %b ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_vectors;
        vec_t vt[12] = '{
            '{32'h40F00000, 32'h400CCCCD, 32'h41840000, 4'b0001},
            '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
            '{32'hC0000000, 32'h00000000, 32'h80000000, 4'b0000},
            '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101},
            '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011},
            '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000},
            '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000},
            '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000},
            '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001},
            '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001},
            '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001},
            '{32'h40400000, 32'h40A00000, 32'h41700000, 4'b0000}
        };
        out_ready = 1;
        foreach (vt[i]) begin
            int n = 0;
            a = vt[i].a;
            b = vt[i].b;
            in_valid = 1;
            tick();
            in_valid = 0;
            while (!out_valid && n < 8) begin
                tick();
                n++;
            end
            vectors++; if (n != 3) begin errors++; $display("FAIL vec%0d latency: got %0d want 3", i, n); end
            vectors++; if (result !== vt[i].r) begin errors++; $display("FAIL vec%0d result: got %h want %h", i, result, vt[i].r); end
            vectors++; if (flags !== (vt[i].f & FMASK)) begin errors++; $display("FAIL vec%0d flags: got %b want %b", i, flags, vt[i].f & FMASK); end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta[6] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h3F000000, 32'h40400000};
        logic [31:0] tb[6] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40800000, 32'h3F000000, 32'h40A00000};
        logic [31:0] tr[6] = '{32'h3F800000, 32'h40C00000, 32'h40100000, 32'hC1000000, 32'h3E800000, 32'h41700000};
        int sent = 0, got = 0, stalls = 0;
        logic [31:0] held = 0;
        logic stalled = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid = sent < 6;
            a = ta[sent % 6];
            b = tb[sent % 6];
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b stall in_ready c%0d: got %b want 0", c, in_ready); end
                if (stalled) begin
                    vectors++; if (result !== held) begin errors++; $display("FAIL b2b held result c%0d: got %h want %h", c, result, held); end
                end
                held = result;
                stalled = 1;
            end else
                stalled = 0;
            if (out_valid && out_ready) begin
                vectors++; if (result !== tr[got]) begin errors++; $display("FAIL b2b item%0d: got %h want %h", got, result, tr[got]); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        vectors++; if (got != 6) begin errors++; $display("FAIL b2b count: got %0d want 6", got); end
        vectors++; if (stalls != 5) begin errors++; $display("FAIL b2b stall cycles: got %0d want 5", stalls); end
        repeat (4) tick();
    endtask

    task automatic test_reset_midflight;
        int seen = 0, at = 0;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h40000000;
            b = 32'h40400000 + 32'(i);
            in_valid = 1;
            tick();
        end
        in_valid = 0;
        tick();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight pre-reset out_valid: got %b want 1", out_valid); end
        rst_n = 0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight async out_valid: got %b want 0", out_valid); end
        vectors++; if (result !== 32'h0) begin errors++; $display("FAIL midflight result cleared: got %h want 00000000", result); end
        tick();
        rst_n = 1;
        a = 32'h3FC00000;
        b = 32'h3FC00000;
        in_valid = 1;
        tick();
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                seen++;
                at = i;
                vectors++; if (result !== 32'h40100000) begin errors++; $display("FAIL midflight new result: got %h want 40100000", result); end
            end
            tick();
        end
        vectors++; if (seen != 1) begin errors++; $display("FAIL midflight result count: got %0d want 1", seen); end
        vectors++; if (at != 3) begin errors++; $display("FAIL midflight latency: got %0d want 3", at); end
    endtask

    task automatic test_half;
        int n = 0;
        ha = 16'h3E00;
        hb = 16'h4000;
        h_valid = 1;
        tick();
        h_valid = 0;
        while (!h_out_valid && n < 8) begin
            tick();
            n++;
        end
        vectors++; if (n != 3) begin errors++; $display("FAIL half latency: got %0d want 3", n); end
        vectors++; if (h_result !== 16'h4200) begin errors++; $display("FAIL half result: got %h want 4200", h_result); end
        vectors++; if (h_flags !== 4'b0000) begin errors++; $display("FAIL half flags: got %b want 0000", h_flags); end
        tick();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midflight();
        test_half();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

- Parametrised, pipelined IEEE-754 binary floating-point multiplier. Successor to the combinational single-precision `multiplier`.
- Adds configurable exponent/mantissa widths, a 3-stage registered datapath with valid/ready flow control, round-to-nearest-even, special-value handling and exception flags.
- Sits between an operand-issue stage and a result consumer in the physical-synthesis datapath; defaults reproduce binary32.

## Interface
- `EXP_W`, default 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 23: stored mantissa width (hidden bit implicit).
- Derived `W` = 1+EXP_W+MAN_W (32 by default).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  block accepts operands this cycle.
- `input_a`, `input_b`  in  W  IEEE-754 operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  W  packed product.
- `flags`  out  4  {invalid, overflow, underflow, inexact}, aligned with `result`.

## Operation
- Transfer on input occurs when `in_valid && in_ready`. Transfer on output occurs when `out_valid && out_ready`.
- Stage S1: unpack, classify, compute sign = sa^sb and biased exponent sum ea+eb-bias (EXP_W+2 bits, signed).
  - Subnormal inputs are treated as zero (DAZ).
- Stage S2: (MAN_W+1)x(MAN_W+1) product of significands with hidden bit, 2*MAN_W+2 bits.
- Stage S3 normalise:
  - If the product MSB is set, shift right 1 and increment the exponent.
  - Round RNE using guard bit plus sticky OR of remaining bits.
  - Round carry-out renormalises and increments the exponent again.
- Specials, in priority order:
  - NaN operand, or Inf*0: canonical quiet NaN (sign 0, exp all-ones, mantissa MSB 1). Invalid is set only for Inf*0 or signalling NaN.
  - Inf*finite-nonzero: signed Inf, no flags.
  - Zero*finite: signed zero, no flags.
- Range:
  - Final exponent >= 2^EXP_W-1: signed Inf, overflow=1, inexact=1.
  - Final exponent <= 0 with nonzero product: signed zero (FTZ), underflow=1, inexact=1.
- Inexact is set when guard|sticky is 1 for normal results.
- Pipeline registers hold sign, exponent, class bits and valid per stage. The class/special decode is carried alongside the datapath.
- Global stall: the entire pipeline freezes when `out_valid && !out_ready`. No bubble-squeezing.

## Timing
- Latency is 3 cycles: an input accepted at edge N gives `out_valid` high after edge N+3, provided no stall.
- Throughput is 1 result per cycle while `out_ready` is held high.
- `in_ready` = !(`out_valid` && !`out_ready`), combinational from `out_ready`.
- `result`/`flags` are stable while `out_valid && !out_ready`.
- Reset values: all stage valids 0, `out_valid` 0, `result` 0, `flags` 0, `in_ready` 1 after reset.
- Reset mid-operation discards all in-flight operands. No output is produced for them.
- Simultaneous output transfer and input acceptance in the same cycle is required to work with no lost or duplicated item.
- Ordering is strictly FIFO.

## Configuration
- `FP_MUL_FLAGS_EN` defined: exception-flag logic is built and `flags` is driven as specified.
- Not defined: flag logic is removed and `flags` is tied to 4'b0000. `result` is bit-identical in both builds.

## Test plan
- 7.5 x 2.2 (0x40F00000, 0x400CCCCD) -> `result` 0x41840000 (16.5) after 3 cycles, flags 0001 (inexact).
- Inf x 0 (0x7F800000, 0x00000000) -> 0x7FC00000, flags 1000. Also -2.0 x 0 (0xC0000000, 0x00000000) -> 0x80000000, flags 0000.
- Overflow and underflow cases:
  - 0x7F000000 x 0x40000000 -> 0x7F800000, flags 0101.
  - 0x00800000 x 0x3F000000 -> 0x00000000, flags 0011.
- Backpressure: issue 6 back-to-back products, `out_ready` low for cycles 4-8. Required: `in_ready` low while stalled, all 6 results delivered in order, held values unchanged during the stall.
- Reset: deassert `rst_n` with 3 operations in flight. Required: `out_valid` 0 immediately; after release, a new 1.5 x 1.5 -> 0x40100000, and no stale results appear.
- Parametrised binary16 (EXP_W=5, MAN_W=10): 0x3E00 x 0x4000 -> 0x4200, flags 0000.
